// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin sharing of one 4-bit binary-to-Gray converter
// among NUM_REQ valid/ready requesters, with a single-entry registered output
// stage that supports downstream backpressure.

// Shared combinational converter; a 16-way table mux from binary to Gray code.
module gray_conv_b2g4 (
    input  logic [3:0] bin_i,
    output logic [3:0] gray_o
);
    // Lookup table of b ^ (b >> 1) for every 4-bit operand
    always_comb begin
        gray_o = 4'h0;
        case (bin_i)
            4'h0: gray_o = 4'h0;
            4'h1: gray_o = 4'h1;
            4'h2: gray_o = 4'h3;
            4'h3: gray_o = 4'h2;
            4'h4: gray_o = 4'h6;
            4'h5: gray_o = 4'h7;
            4'h6: gray_o = 4'h5;
            4'h7: gray_o = 4'h4;
            4'h8: gray_o = 4'hC;
            4'h9: gray_o = 4'hD;
            4'hA: gray_o = 4'hF;
            4'hB: gray_o = 4'hE;
            4'hC: gray_o = 4'hA;
            4'hD: gray_o = 4'hB;
            4'hE: gray_o = 4'h9;
            4'hF: gray_o = 4'h8;
        endcase
    end
endmodule

module gray_conv_arbiter #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*4-1:0]   req_bin,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_gray,
    output logic [3:0]             out_bin,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy
);
    localparam int unsigned SUM_W = ID_W + 1;

    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_gray_q,  out_gray_d;
    logic [3:0]       out_bin_q,   out_bin_d;
    logic [ID_W-1:0]  out_id_q,    out_id_d;
    logic [ID_W-1:0]  rr_q,        rr_d;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  idx;
    logic [SUM_W-1:0] sum;
    logic [3:0]       win_bin;
    logic [3:0]       win_gray;
    logic             load;
    logic [NUM_REQ-1:0] grant;

    // Round-robin search from rr_q upward with wrap; first valid requester wins
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        sum       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Operand mux feeding the single shared converter
    always_comb begin
        win_bin = 4'h0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                win_bin = req_bin[4*i +: 4];
            end
        end
    end

    gray_conv_b2g4 u_conv (
        .bin_i  (win_bin),
        .gray_o (win_gray)
    );

    // Accept when the output slot is empty or drains this cycle; grant is held off in reset
    always_comb begin
        load  = win_found && (!out_valid_q || out_ready);
        grant = '0;
        if (load) begin
            grant[win_id] = 1'b1;
        end
        req_ready = rst_n ? grant : '0;
        busy      = out_valid_q | (|req_valid);
    end

    // Output stage next state: load replaces, drain clears valid, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_gray_d  = out_gray_q;
        out_bin_d   = out_bin_q;
        out_id_d    = out_id_q;
        rr_d        = rr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_gray_d  = win_gray;
            out_bin_d   = win_bin;
            out_id_d    = win_id;
            rr_d        = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_gray_q  <= 4'h0;
            out_bin_q   <= 4'h0;
            out_id_q    <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_gray_q  <= out_gray_d;
            out_bin_q   <= out_bin_d;
            out_id_q    <= out_id_d;
            rr_q        <= rr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_gray  = out_gray_q;
    assign out_bin   = out_bin_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: vector table of stimulus and expected grants,
// with a scoreboard queue of expected results popped as the consumer drains.
module tb_gray_conv_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_bin;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_gray;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;
    logic        busy;

    gray_conv_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] b;
        logic        r;
        logic [3:0]  er;
        logic        adj;
    } vec_t;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic [1:0] id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic m_ov   = 1'b0;
    logic [3:0] last_gray = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [15:0] b, input logic r,
                       input logic [3:0] er, input logic adj);
        vec_t t;
        t.v = v; t.b = b; t.r = r; t.er = er; t.adj = adj;
        tbl.push_back(t);
    endtask

    // Called just after a falling edge; drives, checks, updates the scoreboard, waits one cycle.
    task automatic step(input vec_t t);
        exp_t e;
        logic [1:0] gid;
        logic [3:0] b;
        req_valid = t.v;
        req_bin   = t.b;
        out_ready = t.r;
        #1;
        check("req_ready", 32'(req_ready), 32'(t.er));
        check("busy", 32'(busy), 32'(m_ov | (|t.v)));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: out_valid set with no expected result at %0t", $time);
            end else begin
                check("out_gray", 32'(out_gray), 32'(sb[0].gray));
                check("out_bin",  32'(out_bin),  32'(sb[0].bin));
                check("out_id",   32'(out_id),   32'(sb[0].id));
                if (t.r) begin
                    if (t.adj) begin
                        check("gray_one_bit_step", 32'($countones(last_gray ^ out_gray)), 32'd1);
                    end
                    last_gray = out_gray;
                    void'(sb.pop_front());
                end
            end
        end
        if (t.er != 4'b0000) begin
            gid = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (t.er[i]) gid = 2'(i);
            end
            b      = t.b[4*gid +: 4];
            e.bin  = b;
            e.gray = b ^ (b >> 1);
            e.id   = gid;
            sb.push_back(e);
        end
        m_ov = (t.er != 4'b0000) | (m_ov & ~t.r);
        @(negedge clk);
    endtask

    task automatic run_table();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_bin   = 16'hFFFF;
        out_ready = 1'b1;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_gray",  32'(out_gray),  32'd0);
        check("reset_out_bin",   32'(out_bin),   32'd0);
        check("reset_out_id",    32'(out_id),    32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;

        // Single requester 2, bin 1011 -> gray 1110
        add(4'b0100, 16'h0B00, 1'b1, 4'b0100, 1'b0);
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0);
        // Move priority to 0, then all four streaming with bins 0,5,10,15
        add(4'b1000, 16'hFA50, 1'b1, 4'b1000, 1'b0);
        add(4'b1111, 16'hFA50, 1'b1, 4'b0001, 1'b0);
        add(4'b1111, 16'hFA50, 1'b1, 4'b0010, 1'b0);
        add(4'b1111, 16'hFA50, 1'b1, 4'b0100, 1'b0);
        add(4'b1111, 16'hFA50, 1'b1, 4'b1000, 1'b0);
        add(4'b1111, 16'hFA50, 1'b1, 4'b0001, 1'b0);
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0);
        // Backpressure: result pending, req 1 stalled for 5 cycles, then drain+load together
        add(4'b0010, 16'h0030, 1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) add(4'b0010, 16'h0070, 1'b0, 4'b0000, 1'b0);
        add(4'b0010, 16'h0070, 1'b1, 4'b0010, 1'b0);
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0);
        // Fairness: with priority at 1, pulsed req 3 beats held req 0, then wrap to 0
        add(4'b0001, 16'h0001, 1'b1, 4'b0001, 1'b0);
        add(4'b1001, 16'h9002, 1'b1, 4'b1000, 1'b0);
        add(4'b0001, 16'h0002, 1'b1, 4'b0001, 1'b0);
        // Idle cycle must not move priority away from 1
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0);
        add(4'b0011, 16'h0054, 1'b1, 4'b0010, 1'b0);
        add(4'b0001, 16'h0004, 1'b1, 4'b0001, 1'b0);
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0);
        // Sweep all 16 codes through requester 1
        for (int b = 0; b < 16; b++) begin
            add(4'b0010, 16'(b) << 4, 1'b1, 4'b0010, (b >= 2));
        end
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1);
        run_table();

        // Asynchronous reset while a result is pending (priority left at 3)
        add(4'b0100, 16'h0500, 1'b1, 4'b0100, 1'b0);
        run_table();
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_req_ready", 32'(req_ready), 32'd0);
        check("async_reset_out_gray",  32'(out_gray),  32'd0);
        check("async_reset_out_id",    32'(out_id),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_ov = 1'b0;
        // Priority restarts at 0: req 1 wins over req 3
        add(4'b1010, 16'h3040, 1'b1, 4'b0010, 1'b0);
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0);
        run_table();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one 4-bit binary-to-Gray converter (existing combinational mux-based converter, instantiated once) among NUM_REQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Registers the converted result, with the source ID, into a single-entry output stage that supports downstream backpressure.
- Sits between producer blocks and a shared result consumer. Gives at most one conversion per cycle.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; synchronous deassertion is handled externally.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_bin  input  NUM_REQ*4  packed binary operands; requester i occupies bits [4i+3:4i].
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_gray  output  4  Gray code of the accepted operand.
- out_bin  output  4  original binary operand, for checking.
- out_id  output  ID_W  index of the requester that issued the result.
- busy  output  1  out_valid OR any req_valid.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_gray=0, out_bin=0, out_id=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Arbitration (combinational):
  - Starting at rr_ptr and searching upward with wrap, the first i with req_valid[i]=1 is the winner.
  - No winner when req_valid==0.
- load = winner exists AND (out_valid==0 OR out_ready==1).
- req_ready[winner] = load; all other req_ready bits are 0. req_ready never depends on req_bin.
- A transfer on requester i occurs when req_valid[i] AND req_ready[i] at a rising edge.
- On a transfer from i:
  - out_bin <= req_bin[i]
  - out_gray <= converter(req_bin[i]), which equals b ^ (b>>1)
  - out_id <= i
  - out_valid <= 1
  - rr_ptr <= (i+1) mod NUM_REQ
- Latency: 1 cycle from request acceptance to out_valid.
- Throughput: one result per cycle while out_ready stays high.
- Output drain:
  - If out_valid AND out_ready AND no load: out_valid <= 0. Data registers hold their last values.
  - Simultaneous drain and load: the new result replaces the old in the same edge, with no bubble.
- Backpressure: while out_valid=1 and out_ready=0, all out_* outputs hold stable and every req_ready=0.
- rr_ptr changes only on a transfer. An idle cycle or a stall never moves priority.
- Fairness: a continuously asserted requester is granted within NUM_REQ transfers.
- Requester protocol: once req_valid is asserted, the requester holds req_valid and req_bin stable until its transfer. Bench asserts this; the DUT does not check it.
- Reset mid-operation: a pending result is discarded, out_valid=0 immediately (async), and priority returns to requester 0.
- out_ready while out_valid=0 is ignored.
- Structure:
  - No internal FSM beyond the valid bit and pointer.
  - The converter instance is purely combinational on the muxed operand.
  - Do not duplicate the converter per requester.

Test Plan:
- Reset, then only req 2 valid with req_bin=4'b1011, out_ready=1 -> req_ready=4'b0100 in that cycle. Next cycle out_valid=1, out_gray=4'b1110, out_bin=4'b1011, out_id=2.
- All 4 requesters valid continuously with bins 0,5,10,15 (out_ready=1) -> grant order 0,1,2,3,0,... Gray results 0000,0111,1111,1000 in that order, one per cycle, no gaps.
- Result pending with out_ready=0 for 5 cycles, req 1 valid -> out_* stable and req_ready=0 for all 5 cycles. On out_ready=1, the pending result drains and req 1 loads in the same edge.
- Fairness: req 0 held valid while req 3 pulses valid. With rr_ptr=1, req 3 is granted before req 0's next grant, and rr_ptr then wraps to 0.
- Sweep binary 0..15 through requester 1 -> out_gray matches b^(b>>1) for all 16 codes, and consecutive codes differ in exactly one bit.
- Assert rst_n=0 asynchronously mid-cycle while out_valid=1 -> out_valid drops before the next clk edge. After release, the first grant goes to the lowest-index valid requester starting from 0.
